// File: rtl/inst_sequencer_if.sv
// inst_sequencer_if: start/stop control, instruction/data memory handshakes and datapath strobes of the sequencer.
interface inst_sequencer_if #(
    parameter int INST_W = 26,
    parameter int PC_W   = 16
);
    logic              start;
    logic              stop;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic              imem_valid;
    logic              dmem_req;
    logic              dmem_we;
    logic              dmem_ready;
    logic              branch_taken;
    logic              alu_en;
    logic              reg_we;
    logic [1:0]        inst_class;
    logic [INST_W-1:0] ir;
    logic [PC_W-1:0]   pc;
    logic              busy;
    logic              retired;
    logic              err;
    modport master (
        input  start, stop, imem_rdata, imem_valid, dmem_ready, branch_taken,
        output imem_req, imem_addr, dmem_req, dmem_we, alu_en, reg_we,
               inst_class, ir, pc, busy, retired, err
    );
    modport slave (
        output start, stop, imem_rdata, imem_valid, dmem_ready, branch_taken,
        input  imem_req, imem_addr, dmem_req, dmem_we, alu_en, reg_we,
               inst_class, ir, pc, busy, retired, err
    );
endinterface

// File: rtl/inst_sequencer.sv
// inst_sequencer: multicycle fetch/decode/execute controller owning pc and ir,
// sequencing memory handshakes, ALU enable and register write per instruction class.
module inst_sequencer #(
    parameter int INST_W      = 26,
    parameter int PC_W        = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input logic             clk,
    input logic             rst,
    inst_sequencer_if.master bus
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB} state_t;
    state_t            r_state, w_next, w_done;
    logic [PC_W-1:0]   r_pc, w_off;
    logic [INST_W-1:0] r_ir;
    logic [CW-1:0]     r_cnt;
    logic              r_err;
    logic [1:0]        w_cls;
    logic              w_store, w_timeout;
    assign w_cls     = r_ir[INST_W-1 -: 2];
    assign w_store   = r_ir[23];
    assign w_off     = PC_W'($signed(r_ir[15:0]));
    assign w_done    = bus.stop ? IDLE : FETCH;
    // abort on the last allowed MEM cycle so dmem_req stays high exactly MEM_TIMEOUT cycles
    assign w_timeout = r_state == MEM && !bus.dmem_ready && r_cnt == CW'(MEM_TIMEOUT - 1);
    assign bus.imem_req   = r_state == FETCH;
    assign bus.imem_addr  = r_pc;
    assign bus.dmem_req   = r_state == MEM;
    assign bus.dmem_we    = r_state == MEM && w_store;
    assign bus.alu_en     = r_state == EXEC && w_cls == 2'b00;
    assign bus.reg_we     = r_state == WB;
    assign bus.inst_class = w_cls;
    assign bus.ir         = r_ir;
    assign bus.pc         = r_pc;
    assign bus.busy       = r_state != IDLE;
    assign bus.err        = r_err;
    assign bus.retired    = r_state == WB || (r_state == EXEC && w_cls == 2'b11) ||
                            (r_state == MEM && bus.dmem_ready && w_store);
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start ? FETCH : IDLE;
            FETCH:   w_next = bus.imem_valid ? DECODE : FETCH;
            DECODE:  w_next = EXEC;
            EXEC:    w_next = w_cls == 2'b01 ? MEM : w_cls == 2'b11 ? w_done : WB;
            MEM:     w_next = bus.dmem_ready ? (w_store ? w_done : WB) : w_timeout ? IDLE : MEM;
            WB:      w_next = w_done;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= r_state == MEM ? r_cnt + 1'b1 : '0;
            if (r_state == FETCH && bus.imem_valid)
                r_ir <= bus.imem_rdata;
            if (bus.retired)
                r_pc <= r_pc + ((r_state == EXEC && bus.branch_taken) ? w_off : PC_W'(1));
            if (w_timeout)
                r_err <= 1'b1;
        end
    end
endmodule
